// File: rtl/adder_tree_acc.sv
// adder_tree_acc: binary adder tree over one input beat, optional register
// after any tree stage, and a group accumulator that reports a sum and a beat
// count whenever a group closes (on ACC_N beats or on i_last).

// One tree stage: adds adjacent pairs and widens by one bit. An odd leftover
// element passes through, extended by one bit.
module adder_tree_stage #(
  parameter int IN_N   = 2,
  parameter int IN_W   = 1,
  parameter bit SIGNED = 1'b0,
  localparam int OUT_N = (IN_N + 1) / 2
) (
  input  logic [IN_N-1:0][IN_W-1:0] in_data,
  output logic [OUT_N-1:0][IN_W:0]  out_data
);

  function automatic logic [IN_W:0] ext(input logic [IN_W-1:0] x);
    return {SIGNED & x[IN_W-1], x};
  endfunction

  for (genvar k = 0; k < OUT_N; k++) begin : g_pair
    if (2 * k + 1 < IN_N) begin : g_add
      assign out_data[k] = ext(in_data[2*k]) + ext(in_data[2*k+1]);
    end else begin : g_pass
      assign out_data[k] = ext(in_data[2*k]);
    end
  end

endmodule

module adder_tree_acc #(
  parameter int                        DATA_W = 5,
  parameter int                        DATA_N = 7,
  parameter logic [$clog2(DATA_N)-1:0] FF_P   = '0,
  parameter int                        SIGNED = 0,
  parameter int                        ACC_N  = 4,
  localparam int STAGES_N = $clog2(DATA_N),
  localparam int ACC_W    = $clog2(ACC_N),
  localparam int CNT_W    = $clog2(ACC_N + 1),
  localparam int O_DATA_W = DATA_W + STAGES_N + ACC_W
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            i_valid,
  input  logic [0:DATA_N-1][DATA_W-1:0]   i_data,
  input  logic                            i_last,
  output logic                            o_valid,
  output logic [O_DATA_W-1:0]             o_data,
  output logic [CNT_W-1:0]                o_cnt
);

  localparam int T_W = DATA_W + STAGES_N;

  // Element count entering stage s (ceil-halving per stage).
  function automatic int n_at(input int s);
    int n = DATA_N;
    for (int i = 0; i < s; i++) n = (n + 1) / 2;
    return n;
  endfunction

  for (genvar s = 0; s < STAGES_N; s++) begin : g_stage
    localparam int IN_N  = n_at(s);
    localparam int OUT_N = n_at(s + 1);
    localparam int IN_W  = DATA_W + s;

    logic [IN_N-1:0][IN_W-1:0]  din;
    logic                       vin, lin;
    logic [OUT_N-1:0][IN_W:0]   sum;
    logic [OUT_N-1:0][IN_W:0]   dout;
    logic                       vout, lout;

    if (s == 0) begin : g_src
      // last only means something on a valid beat
      assign din = i_data;
      assign vin = i_valid;
      assign lin = i_last & i_valid;
    end else begin : g_src
      assign din = g_stage[s-1].dout;
      assign vin = g_stage[s-1].vout;
      assign lin = g_stage[s-1].lout;
    end

    adder_tree_stage #(
      .IN_N  (IN_N),
      .IN_W  (IN_W),
      .SIGNED(SIGNED != 0)
    ) u_add (
      .in_data (din),
      .out_data(sum)
    );

    if (FF_P[s]) begin : g_ff
      logic [OUT_N-1:0][IN_W:0] q;
      logic                     qv, ql;
      // register this stage's sums together with their valid/last flags
      always_ff @(posedge clk) begin
        if (rst) begin
          q  <= '0;
          qv <= 1'b0;
          ql <= 1'b0;
        end else begin
          q  <= sum;
          qv <= vin;
          ql <= lin;
        end
      end
      assign dout = q;
      assign vout = qv;
      assign lout = ql;
    end else begin : g_comb
      assign dout = sum;
      assign vout = vin;
      assign lout = lin;
    end
  end

  logic [T_W-1:0]      t_data;
  logic                t_valid, t_last;
  logic [O_DATA_W-1:0] t_ext, acc, acc_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic                close;

  assign t_data  = g_stage[STAGES_N-1].dout;
  assign t_valid = g_stage[STAGES_N-1].vout;
  assign t_last  = g_stage[STAGES_N-1].lout;

  // extend the tree sum, build the running sum and decide group closure
  always_comb begin
    t_ext   = (SIGNED != 0) ? O_DATA_W'($signed(t_data)) : O_DATA_W'(t_data);
    acc_nxt = acc + t_ext;
    cnt_nxt = cnt + CNT_W'(1);
    close   = t_valid && (t_last || cnt_nxt == CNT_W'(ACC_N));
  end

  // accumulate beats; on closure report the group and restart from zero
  always_ff @(posedge clk) begin
    if (rst) begin
      acc     <= '0;
      cnt     <= '0;
      o_valid <= 1'b0;
      o_data  <= '0;
      o_cnt   <= '0;
    end else begin
      o_valid <= close;
      if (close) begin
        acc    <= '0;
        cnt    <= '0;
        o_data <= acc_nxt;
        o_cnt  <= cnt_nxt;
      end else if (t_valid) begin
        acc <= acc_nxt;
        cnt <= cnt_nxt;
      end
    end
  end

endmodule

// File: tb/tb_adder_tree_acc.sv
// Bench for adder_tree_acc: nine instances share one stimulus stream; eight
// unsigned ones cover every FF_P value, the ninth is signed with FF_P=3'b101.
// A group-level model predicts each report's value, count and arrival cycle.
module tb_adder_tree_acc;
  localparam int DATA_W = 5;
  localparam int DATA_N = 7;
  localparam int ACC_N  = 4;
  localparam int NDUT   = 9;
  localparam int OW     = 10;
  localparam int CW     = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                          rst, i_valid, i_last;
  logic [0:DATA_N-1][DATA_W-1:0] i_data;
  logic [NDUT-1:0]               ov;
  logic [NDUT-1:0][OW-1:0]       od;
  logic [NDUT-1:0][CW-1:0]       oc;

  for (genvar j = 0; j < NDUT; j++) begin : g_dut
    adder_tree_acc #(
      .DATA_W(DATA_W),
      .DATA_N(DATA_N),
      .FF_P  ((j < 8) ? 3'(j) : 3'b101),
      .SIGNED((j == 8) ? 1 : 0),
      .ACC_N (ACC_N)
    ) u_dut (
      .clk    (clk),
      .rst    (rst),
      .i_valid(i_valid),
      .i_data (i_data),
      .i_last (i_last),
      .o_valid(ov[j]),
      .o_data (od[j]),
      .o_cnt  (oc[j])
    );
  end

  typedef struct {
    int due;
    int data;
    int cnt;
  } exp_t;

  exp_t q[NDUT][$];
  int   lat[NDUT];
  int   last_d[NDUT];
  int   last_c[NDUT];
  int   cyc, n_chk, n_err;
  int   acc_u, acc_s, gcnt;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic fill(input int val);
    for (int k = 0; k < DATA_N; k++) i_data[k] = DATA_W'(val);
  endtask

  // Apply one cycle of input, advance the model, then check every instance.
  task automatic step(input bit v, input bit l, input bit r);
    exp_t e;
    i_valid = v;
    i_last  = l;
    rst     = r;
    if (r) begin
      for (int j = 0; j < NDUT; j++) begin
        q[j].delete();
        last_d[j] = 0;
        last_c[j] = 0;
      end
      acc_u = 0; acc_s = 0; gcnt = 0;
    end else if (v) begin
      for (int k = 0; k < DATA_N; k++) begin
        acc_u += int'(i_data[k]);
        acc_s += int'($signed(i_data[k]));
      end
      gcnt++;
      if (l || gcnt == ACC_N) begin
        for (int j = 0; j < NDUT; j++) begin
          e.due  = cyc + lat[j] + 1;
          e.data = ((j == 8) ? acc_s : acc_u) & ((1 << OW) - 1);
          e.cnt  = gcnt;
          q[j].push_back(e);
        end
        acc_u = 0; acc_s = 0; gcnt = 0;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int j = 0; j < NDUT; j++) begin
      if (q[j].size() > 0 && q[j][0].due == cyc) begin
        e = q[j].pop_front();
        chk($sformatf("dut%0d_valid", j), int'(ov[j]), 1);
        chk($sformatf("dut%0d_data", j), int'(od[j]), e.data);
        chk($sformatf("dut%0d_cnt", j), int'(oc[j]), e.cnt);
        last_d[j] = e.data;
        last_c[j] = e.cnt;
      end else begin
        chk($sformatf("dut%0d_valid", j), int'(ov[j]), 0);
        chk($sformatf("dut%0d_hold_data", j), int'(od[j]), last_d[j]);
        chk($sformatf("dut%0d_hold_cnt", j), int'(oc[j]), last_c[j]);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    cyc = 0; n_chk = 0; n_err = 0;
    acc_u = 0; acc_s = 0; gcnt = 0;
    for (int j = 0; j < NDUT; j++) begin
      lat[j]    = (j < 8) ? $countones(j) : 2;
      last_d[j] = 0;
      last_c[j] = 0;
    end
    fill(0);
    i_valid = 1'b0; i_last = 1'b0; rst = 1'b1;

    // reset, with a beat presented during reset that must be dropped
    step(1'b0, 1'b0, 1'b1);
    fill(7);
    step(1'b1, 1'b1, 1'b1);
    chk("reset_data", int'(od[0]), 0);
    chk("reset_cnt", int'(oc[0]), 0);

    // unsigned full group of all-31 beats
    fill(31);
    repeat (4) step(1'b1, 1'b0, 1'b0);
    idle(5);
    chk("full_data", int'(od[0]), 868);
    chk("full_cnt", int'(oc[0]), 4);
    chk("pipe101_data", int'(od[5]), 868);

    // signed: all elements -16
    fill(16);
    repeat (4) step(1'b1, 1'b0, 1'b0);
    idle(5);
    chk("signed_data", int'(od[8]), 'h240);
    chk("signed_cnt", int'(oc[8]), 4);

    // early close with idle gaps, then a full group of 2s
    fill(1);
    step(1'b1, 1'b0, 1'b0);
    idle(2);
    step(1'b1, 1'b1, 1'b0);
    chk("early_data", int'(od[0]), 14);
    chk("early_cnt", int'(oc[0]), 2);
    fill(2);
    repeat (4) step(1'b1, 1'b0, 1'b0);
    idle(5);
    chk("after_early_data", int'(od[0]), 56);
    chk("after_early_cnt", int'(oc[0]), 4);

    // reset in the middle of a group
    fill(5);
    repeat (2) step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    chk("midrst_data", int'(od[3]), 0);
    chk("midrst_cnt", int'(oc[3]), 0);
    fill(1);
    repeat (4) step(1'b1, 1'b0, 1'b0);
    idle(5);
    chk("midrst_after_data", int'(od[7]), 28);
    chk("midrst_after_cnt", int'(oc[7]), 4);

    // random traffic with occasional resets
    for (int n = 0; n < 10000; n++) begin
      for (int k = 0; k < DATA_N; k++) i_data[k] = DATA_W'($urandom);
      step(($urandom % 4) != 0, ($urandom % 5) == 0, ($urandom % 400) == 0);
    end
    idle(6);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/adder_tree_acc.md
ADDER_TREE_ACC -- requirements
Module: adder_tree_acc

Interface
REQ-001 The block SHALL have the following parameters:
- DATA_W, default 5: width of each i_data element.
- DATA_N, default 7: number of i_data elements, DATA_N >= 2.
- FF_P, default '0, width STAGES_N: bit s = 1 places a register after tree stage s (bit 0 = first stage).
- SIGNED, default 0: 0 = unsigned, 1 = two's complement.
- ACC_N, default 4: maximum beats per accumulation group, ACC_N >= 1.
REQ-002 The block SHALL have the following localparams:
- STAGES_N = $clog2(DATA_N).
- ACC_W = $clog2(ACC_N).
- CNT_W = $clog2(ACC_N+1).
- O_DATA_W = DATA_W + STAGES_N + ACC_W.
REQ-003 The block SHALL have the following ports:
- clk, input, 1: sole clock.
- rst, input, 1: reset; synchronous, active-high.
- i_valid, input, 1: i_data/i_last valid this cycle.
- i_data, input, [0:DATA_N-1][DATA_W-1:0]: input vector.
- i_last, input, 1: closes the group early; sampled only with i_valid.
- o_valid, output, 1: single-cycle pulse, o_data/o_cnt valid.
- o_data, output, O_DATA_W: group sum.
- o_cnt, output, CNT_W: number of beats in the reported group.

Function
REQ-004 The tree SHALL sum all DATA_N elements of a beat in STAGES_N binary stages.
- Each stage adds adjacent pairs and widens by 1 bit.
- An odd leftover element passes through to the next stage, extended by 1 bit.
REQ-005 Extension SHALL be sign extension when SIGNED=1 and zero extension when SIGNED=0, at every stage and into the accumulator; no overflow is possible at O_DATA_W.
REQ-006 Each stage s with FF_P[s]=1 SHALL register the data together with its valid and last flags; stage latency L = number of set bits in FF_P, and FF_P='0 gives a purely combinational tree.
REQ-007 The accumulator SHALL be a register stage that adds each valid tree sum and counts the beats in the current group; idle cycles (i_valid=0) SHALL neither add nor count.
REQ-008 A group SHALL close on the beat that makes the count ACC_N, or on a valid beat with i_last=1, whichever comes first; that closing beat is included in the sum.
REQ-009 On closure, the block SHALL assert o_valid for exactly one cycle, L+1 cycles after the closing beat at the input.
- o_data = the full group sum.
- o_cnt = the number of beats in the group.
REQ-010 When a group closes, the next valid beat SHALL start a new group from zero.
- Back-to-back groups are supported with no lost beats.
- With ACC_N=1, every valid beat produces its own output.
REQ-011 Between pulses, o_data and o_cnt SHALL hold the last reported values.
REQ-012 i_last with i_valid=0 SHALL be ignored.
REQ-013 The block SHALL have no backpressure; i_valid may be asserted every cycle at full throughput.

Reset
REQ-014 While rst=1 at a clk edge, the block SHALL clear all pipeline valid/last flags, the data registers, the accumulator and the beat count; o_valid=0, o_data=0, o_cnt=0.
REQ-015 Beats in flight or partially accumulated when rst asserts SHALL be discarded and never reported.
REQ-016 A beat presented in the same cycle as rst=1 SHALL be discarded.
REQ-017 Normal operation SHALL resume on the first edge with rst=0.

Verification
REQ-018 The bench SHALL cover the following scenarios:
- Unsigned full group: DATA_W=5, DATA_N=7, FF_P=3'b000, SIGNED=0, ACC_N=4; 4 consecutive beats with all elements 31 -> one o_valid 1 cycle after beat 4, o_data=868, o_cnt=4.
- Pipelined latency: same stimulus with FF_P=3'b101 -> o_valid 3 cycles after beat 4, o_data=868; o_valid low in every other cycle.
- Signed: SIGNED=1, all elements 5'b10000 (-16), 4 beats -> o_data=10'h240 (-448), o_cnt=4.
- Early close plus idle gaps: all elements 1, beats on cycles 0 and 3 with i_last=1 on cycle 3, then 4 beats of 2 -> first o_data=14, o_cnt=2; second o_data=56, o_cnt=4.
- Reset mid-group: 2 beats of value 5, rst for 1 cycle, then 4 beats of value 1 -> exactly one output, o_data=28, o_cnt=4; outputs read 0 right after reset.
- Random: $random data and i_valid/i_last for 10k cycles, FF_P swept over all values -> every output matches the reference-model sum, count and timing.
